// File: rtl/timer_pkg.sv
// Shared types and constants for the timer sequencing controller.
package timer_pkg;

  localparam int CNT_W  = 64;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    RLD_LO = 3'd2,
    RLD_HI = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam logic [STRB_W-1:0] STRB_ALL = 4'hF;

  function automatic logic is_reload(input state_e s);
    return (s == RLD_LO) || (s == RLD_HI);
  endfunction

endpackage

// File: rtl/cmp_edge.sv
// Counter/compare equality with a one-cycle delayed copy, so a count that
// sits on the compare value yields a single rising-edge event.
module cmp_edge #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] count,
  input  logic [W-1:0] cmp_val,
  output logic         evt_rise
);

  logic match;
  logic match_dly_d;
  logic match_dly_q;

  assign match       = (count == cmp_val);
  assign match_dly_d = match;
  assign evt_rise    = match & ~match_dly_q;

  // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) match_dly_q <= 1'b0;
    else        match_dly_q <= match_dly_d;
  end

endmodule

// File: rtl/timer_seq_ctrl.sv
// Drives the 64-bit counter's control inputs: run/stop, one-shot vs periodic
// auto-reload, sticky compare interrupt, and software-first write arbitration.
module timer_seq_ctrl
  import timer_pkg::*;
#(
  parameter int CNT_W  = timer_pkg::CNT_W,
  parameter int DATA_W = timer_pkg::DATA_W,
  parameter int STRB_W = timer_pkg::STRB_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sw_timer_en,
  input  logic              sw_mode,
  input  logic              sw_halt,
  input  logic              sw_wr_DR0,
  input  logic              sw_wr_DR1,
  input  logic [STRB_W-1:0] sw_pstrb,
  input  logic [DATA_W-1:0] sw_wdata,
  input  logic [CNT_W-1:0]  cmp_val,
  input  logic [CNT_W-1:0]  reload_val,
  input  logic              int_en,
  input  logic              int_clr,
  input  logic [CNT_W-1:0]  count,
  output logic              timer_en,
  output logic              stop,
  output logic              wr_DR0,
  output logic              wr_DR1,
  output logic [STRB_W-1:0] pstrb,
  output logic [DATA_W-1:0] wdata,
  output logic              int_st,
  output logic              tim_int,
  output logic              busy
);

  state_e state_q, state_d;
  logic   timer_en_q, timer_en_d;
  logic   int_st_q, int_st_d;
  logic   cmp_rise;
  logic   evt;
  logic   sw_wr;

  cmp_edge #(.W(CNT_W)) u_cmp_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .count    (count),
    .cmp_val  (cmp_val),
    .evt_rise (cmp_rise)
  );

  assign evt   = cmp_rise & (state_q == RUN);
  assign sw_wr = sw_wr_DR0 | sw_wr_DR1;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    wr_DR0  = sw_wr_DR0;
    wr_DR1  = sw_wr_DR1;
    pstrb   = sw_wr ? sw_pstrb : '0;
    wdata   = sw_wr ? sw_wdata : '0;

    unique case (state_q)
      IDLE: if (sw_timer_en) state_d = RUN;
      RUN: begin
        if (evt) state_d = (sw_mode == MODE_PERIODIC) ? RLD_LO : DONE;
      end
      // A software write owns the bus this cycle; the reload step waits.
      RLD_LO: begin
        if (!sw_wr) begin
          wr_DR0  = 1'b1;
          pstrb   = STRB_W'(STRB_ALL);
          wdata   = reload_val[DATA_W-1:0];
          state_d = RLD_HI;
        end
      end
      RLD_HI: begin
        if (!sw_wr) begin
          wr_DR1  = 1'b1;
          pstrb   = STRB_W'(STRB_ALL);
          wdata   = reload_val[CNT_W-1:DATA_W];
          state_d = RUN;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase

    // Disabling wins from any state and abandons a pending reload half.
    if (!sw_timer_en) state_d = IDLE;

    timer_en_d = (state_d == RUN) || is_reload(state_d);

    if (evt)          int_st_d = 1'b1;
    else if (int_clr) int_st_d = 1'b0;
    else              int_st_d = int_st_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_en_q <= 1'b0;
      int_st_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_en_q <= timer_en_d;
      int_st_q   <= int_st_d;
    end
  end

  assign timer_en = timer_en_q;
  assign busy     = is_reload(state_q);
  assign stop     = sw_halt | busy;
  assign int_st   = int_st_q;
  assign tim_int  = int_st_q & int_en;

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Directed bench for timer_seq_ctrl; the bench plays the counter by driving count.
module tb_timer_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sw_timer_en, sw_mode, sw_halt, sw_wr_DR0, sw_wr_DR1;
  logic [3:0]  sw_pstrb;
  logic [31:0] sw_wdata;
  logic [63:0] cmp_val, reload_val, count;
  logic        int_en, int_clr;
  logic        timer_en, stop, wr_DR0, wr_DR1, int_st, tim_int, busy;
  logic [3:0]  pstrb;
  logic [31:0] wdata;

  int n_cmp = 0;
  int n_err = 0;

  timer_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .sw_timer_en(sw_timer_en), .sw_mode(sw_mode),
    .sw_halt(sw_halt), .sw_wr_DR0(sw_wr_DR0), .sw_wr_DR1(sw_wr_DR1),
    .sw_pstrb(sw_pstrb), .sw_wdata(sw_wdata), .cmp_val(cmp_val),
    .reload_val(reload_val), .int_en(int_en), .int_clr(int_clr), .count(count),
    .timer_en(timer_en), .stop(stop), .wr_DR0(wr_DR0), .wr_DR1(wr_DR1),
    .pstrb(pstrb), .wdata(wdata), .int_st(int_st), .tim_int(tim_int), .busy(busy)
  );

  always #5 clk = ~clk;

  // Control bits: {timer_en, stop, wr_DR0, wr_DR1, busy, int_st, tim_int}
  function automatic logic [6:0] ctl();
    return {timer_en, stop, wr_DR0, wr_DR1, busy, int_st, tim_int};
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_int();
    int_clr = 1'b1;
    next();
    int_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sw_timer_en = 0; sw_mode = 0; sw_halt = 0; sw_wr_DR0 = 0; sw_wr_DR1 = 0;
    sw_pstrb = '0; sw_wdata = '0; cmp_val = '0; reload_val = '0; count = '0;
    int_en = 0; int_clr = 0;
    #2;
    n_cmp++;
    if (ctl() !== 7'b0000000) begin
      n_err++; $display("FAIL reset_ctl: got %b exp %b", ctl(), 7'b0000000);
    end
    n_cmp++;
    if ({pstrb, wdata} !== 36'h0) begin
      n_err++; $display("FAIL reset_bus: got pstrb=%h wdata=%h exp 0/0", pstrb, wdata);
    end
    settle();
    rst_n = 1'b1;
    next();
    int_en = 1'b1;
  endtask

  task automatic test_oneshot();
    cmp_val = 64'h10; sw_mode = 1'b0; count = '0; sw_timer_en = 1'b1;
    next();
    for (int i = 0; i <= 16; i++) begin
      count = 64'(i);
      settle();
      n_cmp++;
      if (ctl() !== 7'b1000000) begin
        n_err++; $display("FAIL oneshot_run[%0d]: got %b exp %b", i, ctl(), 7'b1000000);
      end
      next();
    end
    count = 64'h11;
    for (int k = 0; k < 3; k++) begin
      settle();
      n_cmp++;
      if (ctl() !== 7'b0000011) begin
        n_err++; $display("FAIL oneshot_done[%0d]: got %b exp %b", k, ctl(), 7'b0000011);
      end
      next();
    end
    sw_timer_en = 1'b0;
    next();
    count = '0;
    settle();
    n_cmp++;
    if (ctl() !== 7'b0000011) begin
      n_err++; $display("FAIL oneshot_idle: got %b exp %b", ctl(), 7'b0000011);
    end
    sw_timer_en = 1'b1;
    next();
    n_cmp++;
    if (ctl() !== 7'b1000011) begin
      n_err++; $display("FAIL oneshot_rearm: got %b exp %b", ctl(), 7'b1000011);
    end
    sw_timer_en = 1'b0;
    next();
    clear_int();
    settle();
    n_cmp++;
    if (ctl() !== 7'b0000000) begin
      n_err++; $display("FAIL oneshot_clr: got %b exp %b", ctl(), 7'b0000000);
    end
  endtask

  task automatic test_periodic();
    cmp_val = 64'h0000_0001_0000_0005; reload_val = 64'h0000_0001_0000_0000;
    sw_mode = 1'b1; count = 64'h0000_0001_0000_0003; sw_timer_en = 1'b1;
    next();
    next(); count = 64'h0000_0001_0000_0004;
    next(); count = 64'h0000_0001_0000_0005;
    settle();
    n_cmp++;
    if (ctl() !== 7'b1000000) begin
      n_err++; $display("FAIL per_evt_cycle: got %b exp %b", ctl(), 7'b1000000);
    end
    next();
    settle();
    n_cmp++;
    if ({ctl(), pstrb, wdata} !== {7'b1110111, 4'hF, 32'h0}) begin
      n_err++; $display("FAIL per_rld_lo: got %b/%h/%h exp %b/f/0", ctl(), pstrb, wdata, 7'b1110111);
    end
    next();
    settle();
    n_cmp++;
    if ({ctl(), pstrb, wdata} !== {7'b1101111, 4'hF, 32'h1}) begin
      n_err++; $display("FAIL per_rld_hi: got %b/%h/%h exp %b/f/1", ctl(), pstrb, wdata, 7'b1101111);
    end
    next();
    count = 64'h0000_0001_0000_0000;
    settle();
    n_cmp++;
    if ({ctl(), pstrb, wdata} !== {7'b1000011, 4'h0, 32'h0}) begin
      n_err++; $display("FAIL per_back_run: got %b/%h/%h exp %b/0/0", ctl(), pstrb, wdata, 7'b1000011);
    end
    sw_timer_en = 1'b0;
    next();
    clear_int();
  endtask

  task automatic test_arbitration();
    count = 64'h0000_0001_0000_0003; sw_timer_en = 1'b1;
    next();
    sw_wr_DR0 = 1'b1; sw_wdata = 32'h1234_5678; sw_pstrb = 4'h5;
    settle();
    n_cmp++;
    if ({ctl(), pstrb, wdata} !== {7'b1010000, 4'h5, 32'h1234_5678}) begin
      n_err++; $display("FAIL arb_run_pass: got %b/%h/%h exp %b/5/12345678", ctl(), pstrb, wdata, 7'b1010000);
    end
    sw_wr_DR0 = 1'b0; sw_wdata = '0; sw_pstrb = '0;
    next(); count = 64'h0000_0001_0000_0004;
    next(); count = 64'h0000_0001_0000_0005;
    next();
    settle();
    n_cmp++;
    if ({ctl(), wdata} !== {7'b1110111, 32'h0}) begin
      n_err++; $display("FAIL arb_rld_lo: got %b/%h exp %b/0", ctl(), wdata, 7'b1110111);
    end
    next();
    sw_wr_DR1 = 1'b1; sw_wdata = 32'hDEAD_BEEF; sw_pstrb = 4'h3;
    settle();
    n_cmp++;
    if ({ctl(), pstrb, wdata} !== {7'b1101111, 4'h3, 32'hDEAD_BEEF}) begin
      n_err++; $display("FAIL arb_sw_wins: got %b/%h/%h exp %b/3/deadbeef", ctl(), pstrb, wdata, 7'b1101111);
    end
    next();
    sw_wr_DR1 = 1'b0; sw_wdata = '0; sw_pstrb = '0;
    settle();
    n_cmp++;
    if ({ctl(), pstrb, wdata} !== {7'b1101111, 4'hF, 32'h1}) begin
      n_err++; $display("FAIL arb_rld_hi_late: got %b/%h/%h exp %b/f/1", ctl(), pstrb, wdata, 7'b1101111);
    end
    next();
    count = 64'h0000_0001_0000_0000;
    settle();
    n_cmp++;
    if (ctl() !== 7'b1000011) begin
      n_err++; $display("FAIL arb_back_run: got %b exp %b", ctl(), 7'b1000011);
    end
    sw_timer_en = 1'b0;
    next();
    clear_int();
  endtask

  task automatic test_int_clr();
    cmp_val = 64'h20; sw_mode = 1'b0; count = 64'h1F; sw_timer_en = 1'b1;
    next();
    count = 64'h20; int_clr = 1'b1;
    settle();
    n_cmp++;
    if (ctl() !== 7'b1000000) begin
      n_err++; $display("FAIL int_pre_evt: got %b exp %b", ctl(), 7'b1000000);
    end
    next();
    int_clr = 1'b0; count = 64'h21;
    settle();
    n_cmp++;
    if (ctl() !== 7'b0000011) begin
      n_err++; $display("FAIL int_set_wins: got %b exp %b", ctl(), 7'b0000011);
    end
    int_en = 1'b0;
    #1;
    n_cmp++;
    if (ctl() !== 7'b0000010) begin
      n_err++; $display("FAIL int_masked: got %b exp %b", ctl(), 7'b0000010);
    end
    next();
    clear_int();
    int_en = 1'b1;
    settle();
    n_cmp++;
    if (ctl() !== 7'b0000000) begin
      n_err++; $display("FAIL int_cleared: got %b exp %b", ctl(), 7'b0000000);
    end
    sw_timer_en = 1'b0;
    next();
  endtask

  task automatic test_halt_hold();
    int n_dr0 = 0;
    int n_dr1 = 0;
    cmp_val = 64'h40; reload_val = '0; sw_mode = 1'b1; count = 64'h3F;
    sw_timer_en = 1'b1; sw_halt = 1'b1;
    next();
    settle();
    n_cmp++;
    if (ctl() !== 7'b1100000) begin
      n_err++; $display("FAIL halt_run: got %b exp %b", ctl(), 7'b1100000);
    end
    next();
    count = 64'h40;
    for (int k = 0; k < 5; k++) begin
      settle();
      n_dr0 += int'(wr_DR0);
      n_dr1 += int'(wr_DR1);
      n_cmp++;
      if (stop !== 1'b1) begin
        n_err++; $display("FAIL halt_stop[%0d]: got %b exp 1", k, stop);
      end
      next();
    end
    n_cmp++;
    if ({n_dr0, n_dr1} !== {32'd1, 32'd1}) begin
      n_err++; $display("FAIL halt_one_event: got dr0=%0d dr1=%0d exp 1/1", n_dr0, n_dr1);
    end
    settle();
    n_cmp++;
    if (ctl() !== 7'b1100011) begin
      n_err++; $display("FAIL halt_after: got %b exp %b", ctl(), 7'b1100011);
    end
    sw_halt = 1'b0; sw_timer_en = 1'b0;
    next();
    clear_int();
  endtask

  task automatic test_abort();
    cmp_val = 64'h5; reload_val = 64'h0000_0002_0000_0001; sw_mode = 1'b1;
    count = 64'h4; sw_timer_en = 1'b1;
    next();
    count = 64'h5;
    next();
    settle();
    n_cmp++;
    if (ctl() !== 7'b1110111) begin
      n_err++; $display("FAIL abort_rld_lo: got %b exp %b", ctl(), 7'b1110111);
    end
    sw_timer_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      next();
      settle();
      n_cmp++;
      if ({ctl(), wdata} !== {7'b0000011, 32'h0}) begin
        n_err++; $display("FAIL abort_idle[%0d]: got %b/%h exp %b/0", k, ctl(), wdata, 7'b0000011);
      end
    end
    next();
    clear_int();
  endtask

  task automatic test_reset_mid_reload();
    cmp_val = 64'h5; reload_val = 64'h0000_0003_0000_0007; sw_mode = 1'b1;
    count = 64'h4; sw_timer_en = 1'b1;
    next();
    count = 64'h5;
    next();
    settle();
    n_cmp++;
    if ({ctl(), wdata} !== {7'b1110111, 32'h7}) begin
      n_err++; $display("FAIL rst_pre_rld_lo: got %b/%h exp %b/7", ctl(), wdata, 7'b1110111);
    end
    #1;
    rst_n = 1'b0;
    sw_timer_en = 1'b0;
    #1;
    n_cmp++;
    if ({ctl(), pstrb, wdata} !== {7'b0000000, 4'h0, 32'h0}) begin
      n_err++; $display("FAIL rst_mid_rld: got %b/%h/%h exp %b/0/0", ctl(), pstrb, wdata, 7'b0000000);
    end
    next();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      n_cmp++;
      if (ctl() !== 7'b0000000) begin
        n_err++; $display("FAIL rst_no_dr1[%0d]: got %b exp %b", k, ctl(), 7'b0000000);
      end
      next();
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_arbitration();
    test_int_clr();
    test_halt_hold();
    test_abort();
    test_reset_mid_reload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/timer_seq_ctrl.md
Name: timer_seq_ctrl

Overview:
Sequencing controller for the 64-bit APB timer counter. Owns the counter's control inputs (timer_en, stop, wr_DR0/wr_DR1, pstrb, wdata) and generates them from software control plus a 64-bit compare. Supports one-shot and periodic auto-reload modes and raises a sticky compare interrupt. Arbitrates between software (APB) data-register writes and its own reload writes to the counter.

Parameters:
CNT_W, 64, counter width (fixed 2*DATA_W)
DATA_W, 32, APB data / half-counter width
STRB_W, 4, byte-strobe width (DATA_W/8)

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
sw_timer_en  in  1  software timer enable (control register bit)
sw_mode  in  1  0 = one-shot, 1 = periodic auto-reload
sw_halt  in  1  debug halt request; freezes counter
sw_wr_DR0 / sw_wr_DR1  in  1 each  APB write strobe to counter low/high word
sw_pstrb  in  STRB_W  APB byte strobes
sw_wdata  in  DATA_W  APB write data
cmp_val  in  CNT_W  compare value
reload_val  in  CNT_W  periodic reload value
int_en  in  1  interrupt enable
int_clr  in  1  single-cycle write-1-to-clear of int_st
count  in  CNT_W  current counter value
timer_en  out  1  to counter
stop  out  1  to counter
wr_DR0 / wr_DR1  out  1 each  to counter
pstrb  out  STRB_W  to counter
wdata  out  DATA_W  to counter
int_st  out  1  sticky compare status
tim_int  out  1  interrupt = int_st & int_en
busy  out  1  reload sequence in progress

Behaviour:
- Reset: state IDLE; timer_en=0, stop=0, wr_DR0=wr_DR1=0, pstrb=0, wdata=0, int_st=0, tim_int=0, busy=0, match_d=0.
- States: IDLE, RUN, RLD_LO, RLD_HI, DONE.
- IDLE -> RUN when sw_timer_en=1 (next edge). In any state, sw_timer_en=0 -> IDLE at next edge; an in-flight reload is aborted, no further reload write issued.
- timer_en = 1 in RUN, RLD_LO, RLD_HI; 0 in IDLE and DONE (registered from state).
- Match: match = (count == cmp_val); match_d registered each cycle; event = match & ~match_d & (state==RUN). Edge qualification: a held count fires once only.
- Event in cycle N: int_st=1 from N+1. sw_mode sampled at N: one-shot -> DONE (timer_en=0 at N+1); periodic -> RLD_LO.
- RLD_LO: wr_DR0=1, pstrb=4'hF, wdata=reload_val[31:0]; -> RLD_HI. RLD_HI: wr_DR1=1, pstrb=4'hF, wdata=reload_val[63:32]; -> RUN. Reload writes therefore occur at N+1 and N+2.
- stop = sw_halt | (state in RLD_LO, RLD_HI). Counter does not increment during reload.
- busy = 1 in RLD_LO and RLD_HI.
- DONE: held until sw_timer_en=0, then IDLE. Re-arm requires 0->1 on sw_timer_en.
- Arbitration: any sw_wr_DR0/sw_wr_DR1 cycle has priority. sw_wdata, sw_pstrb and sw strobes pass through to outputs combinationally. The reload state holds (no advance, no reload strobe) that cycle and resumes next cycle. Outside reload, software writes always pass through; otherwise wr_*/pstrb/wdata = 0.
- sw_halt in RLD_*: reload still proceeds; stop remains 1.
- int_st: set on event, cleared by int_clr; simultaneous set and clear -> set wins. tim_int is combinational from int_st and int_en.
- Event is ignored in states other than RUN.

Decomposition:
- timer_pkg: state encoding constants (IDLE=0 … DONE=4), MODE_ONESHOT/MODE_PERIODIC, STRB_ALL=4'hF, CNT_W/DATA_W defaults.
- Sub-module cmp_edge: 64-bit equality, match_d register, and event output.

Test Plan:
- Reset mid-RLD_LO (rst_n low for 1 cycle) -> all outputs 0, state IDLE, no wr_DR1 issued.
- One-shot, cmp=0x10, count ramps from 0 -> event when count=0x10; int_st=1 and timer_en=0 next cycle; state DONE held until sw_timer_en=0.
- Periodic, cmp=0x0000_0001_0000_0005, reload=0x0000_0001_0000_0000 -> wr_DR0 with wdata=0 at N+1, wr_DR1 with wdata=1 at N+2; stop=1 both cycles; back to RUN.
- Periodic reload with sw_wr_DR1 (wdata=0xDEADBEEF, pstrb=4'h3) asserted in the RLD_HI cycle -> software write passes through; reload wr_DR1 delayed one cycle with reload_val[63:32].
- int_clr asserted in the same cycle as a new event -> int_st stays 1. int_clr alone -> 0. int_en=0 -> tim_int=0 while int_st=1.
- count held at cmp for 5 cycles with sw_halt=1 -> exactly one event; stop=1 throughout the halt.
